// File: rtl/mem_stage.sv
// Memory stage of the pipeline: byte-addressable data memory with aligned,
// extended loads, byte/half/word stores, fault detection and a debug read port.
module mem_stage #(
    parameter int NB_REG     = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_WB_CTRL = 2,
    parameter int MEM_WORDS  = 64
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_dunit_clk_en,
    input  logic [NB_REG-1:0]            i_alu_result,
    input  logic [NB_REG-1:0]            i_w_data,
    input  logic                         i_mem_read,
    input  logic                         i_mem_write,
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic [NB_REG-1:0]            i_pc_eight,
    input  logic [NB_ADDR-1:0]           i_data_addr,
    input  logic [NB_WB_CTRL-1:0]        i_wb_ctrl,
    input  logic [$clog2(MEM_WORDS)-1:0] i_dunit_mem_addr,
    output logic [NB_REG-1:0]            o_alu_result,
    output logic [NB_REG-1:0]            o_read_data,
    output logic                         o_misaligned,
    output logic [NB_REG-1:0]            o_pc_eight,
    output logic [NB_ADDR-1:0]           o_data_addr,
    output logic [NB_WB_CTRL-1:0]        o_wb_ctrl,
    output logic [NB_REG-1:0]            o_dunit_mem_data
);

    localparam int NB_IDX = $clog2(MEM_WORDS);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    logic [NB_REG-1:0] r_mem [MEM_WORDS];

    logic [NB_IDX-1:0] w_idx;
    logic [1:0]        w_off;
    logic              w_fault;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [NB_REG-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Upper address bits are dropped, so accesses wrap around the memory.
    assign w_idx = i_alu_result[NB_IDX+1:2];
    assign w_off = i_alu_result[1:0];

    assign w_fault = (i_size == 2'b10) ||
                     ((i_size == SIZE_HALF) && w_off[0]) ||
                     ((i_size == SIZE_WORD) && (w_off != 2'b00));

    assign o_misaligned = (i_mem_read || i_mem_write) && w_fault;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (i_size)
            SIZE_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{i_w_data[7:0]}};
            end
            SIZE_HALF: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_w_data[15:0]}};
            end
            SIZE_WORD: begin
                w_be    = 4'b1111;
                w_wdata = i_w_data[31:0];
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_dunit_clk_en && i_mem_write && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    // Loads read the pre-edge contents, so a same-cycle store is not forwarded.
    always_comb begin
        o_read_data = '0;
        if (i_mem_read && !w_fault) begin
            case (i_size)
                SIZE_BYTE: o_read_data = {{(NB_REG-8){~i_unsigned & w_byte[7]}}, w_byte};
                SIZE_HALF: o_read_data = {{(NB_REG-16){~i_unsigned & w_half[15]}}, w_half};
                SIZE_WORD: o_read_data = w_word;
                default:   o_read_data = '0;
            endcase
        end
    end

    assign o_dunit_mem_data = r_mem[i_dunit_mem_addr];
    assign o_alu_result     = i_alu_result;
    assign o_pc_eight       = i_pc_eight;
    assign o_data_addr      = i_data_addr;
    assign o_wb_ctrl        = i_wb_ctrl;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: a table of access vectors whose expected outputs are
// queued on a scoreboard when driven and compared once the outputs settle.
module tb_mem_stage;

    localparam int NB_REG     = 32;
    localparam int NB_ADDR    = 5;
    localparam int NB_WB_CTRL = 2;
    localparam int MEM_WORDS  = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  dunitClkEn;
    logic [NB_REG-1:0]     aluResult;
    logic [NB_REG-1:0]     wData;
    logic                  memRead;
    logic                  memWrite;
    logic [1:0]            size;
    logic                  isUnsigned;
    logic [NB_REG-1:0]     pcEight;
    logic [NB_ADDR-1:0]    dataAddr;
    logic [NB_WB_CTRL-1:0] wbCtrl;
    logic [5:0]            dunitMemAddr;
    logic [NB_REG-1:0]     outAluResult;
    logic [NB_REG-1:0]     readData;
    logic                  misaligned;
    logic [NB_REG-1:0]     outPcEight;
    logic [NB_ADDR-1:0]    outDataAddr;
    logic [NB_WB_CTRL-1:0] outWbCtrl;
    logic [NB_REG-1:0]     dunitMemData;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  dbgAddr;
        logic [31:0] expData;
        logic        expMis;
        logic [31:0] expDbg;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic [31:0] dbg;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  daddr;
        logic [1:0]  wb;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage #(
        .NB_REG    (NB_REG),
        .NB_ADDR   (NB_ADDR),
        .NB_WB_CTRL(NB_WB_CTRL),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_dunit_clk_en  (dunitClkEn),
        .i_alu_result    (aluResult),
        .i_w_data        (wData),
        .i_mem_read      (memRead),
        .i_mem_write     (memWrite),
        .i_size          (size),
        .i_unsigned      (isUnsigned),
        .i_pc_eight      (pcEight),
        .i_data_addr     (dataAddr),
        .i_wb_ctrl       (wbCtrl),
        .i_dunit_mem_addr(dunitMemAddr),
        .o_alu_result    (outAluResult),
        .o_read_data     (readData),
        .o_misaligned    (misaligned),
        .o_pc_eight      (outPcEight),
        .o_data_addr     (outDataAddr),
        .o_wb_ctrl       (outWbCtrl),
        .o_dunit_mem_data(dunitMemData)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic rd, logic wr, logic [1:0] sz,
                                logic uns, logic [31:0] addr, logic [31:0] wdata,
                                logic [5:0] dbgAddr, logic [31:0] expData, logic expMis,
                                logic [31:0] expDbg);
        vec_t v;
        v.rst = rst; v.en = en; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.dbgAddr = dbgAddr;
        v.expData = expData; v.expMis = expMis; v.expDbg = expDbg;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector just after the rising edge; its store commits at the next edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = v.rst;
        dunitClkEn   = v.en;
        memRead      = v.rd;
        memWrite     = v.wr;
        size         = v.sz;
        isUnsigned   = v.uns;
        aluResult    = v.addr;
        wData        = v.wdata;
        dunitMemAddr = v.dbgAddr;
        pcEight      = $urandom;
        dataAddr     = 5'($urandom);
        wbCtrl       = 2'($urandom);
        e.data  = v.expData;
        e.mis   = v.expMis;
        e.dbg   = v.expDbg;
        e.alu   = v.addr;
        e.pc    = pcEight;
        e.daddr = dataAddr;
        e.wb    = wbCtrl;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        string tag;
        @(negedge clk);
        tag = $sformatf("v%0d", idx);
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, required one entry", tag);
        end else begin
            e = scoreboard.pop_front();
            compare({tag, " read_data"}, readData, e.data);
            compare({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, e.mis});
            compare({tag, " dunit_mem_data"}, dunitMemData, e.dbg);
            compare({tag, " alu_result"}, outAluResult, e.alu);
            compare({tag, " pc_eight"}, outPcEight, e.pc);
            compare({tag, " data_addr"}, {27'b0, outDataAddr}, {27'b0, e.daddr});
            compare({tag, " wb_ctrl"}, {30'b0, outWbCtrl}, {30'b0, e.wb});
        end
    endtask

    initial begin
        reset = 1'b1; dunitClkEn = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        size = 2'b11; isUnsigned = 1'b0; aluResult = '0; wData = '0;
        pcEight = '0; dataAddr = '0; wbCtrl = '0; dunitMemAddr = '0;
        repeat (2) @(posedge clk);

        //          rst en rd wr sz     u  addr          wdata         dbg  expData       mis  expDbg
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h10,        32'h0,         0,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1, 2'b11, 0, 32'h10,        32'hDEADBEEF,  63, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 32'h10,        32'h0,         4,  32'hFFFFFFEF, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 32'h11,        32'h0,         4,  32'hFFFFFFBE, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 32'h12,        32'h0,         4,  32'hFFFFFFAD, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 32'h13,        32'h0,         4,  32'hFFFFFFDE, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 1, 32'h13,        32'h0,         4,  32'h000000DE, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b01, 0, 32'h10,        32'h0,         4,  32'hFFFFBEEF, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b01, 1, 32'h12,        32'h0,         4,  32'h0000DEAD, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h10,        32'h0,         4,  32'hDEADBEEF, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 1, 2'b01, 0, 32'h12,        32'hFFFF1234,  4,  32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 1, 2'b00, 1, 32'h11,        32'hFFFFFF55,  4,  32'h000000BE, 0, 32'h1234BEEF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h10,        32'h0,         4,  32'h123455EF, 0, 32'h123455EF));
        vecs.push_back(mk(0, 1, 0, 1, 2'b11, 0, 32'h22,        32'h11111111,  8,  32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h20,        32'h0,         8,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b01, 0, 32'h21,        32'h0,         8,  32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b10, 0, 32'h10,        32'h0,         4,  32'h0,        1, 32'h123455EF));
        vecs.push_back(mk(0, 1, 0, 1, 2'b01, 0, 32'h13,        32'h9999,      4,  32'h0,        1, 32'h123455EF));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h10,        32'h0,         4,  32'h123455EF, 0, 32'h123455EF));
        vecs.push_back(mk(0, 0, 1, 1, 2'b11, 0, 32'h04,        32'hCAFEF00D,  1,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1, 2'b11, 0, 32'h04,        32'hCAFEF00D,  1,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h04,        32'h0,         1,  32'hCAFEF00D, 0, 32'hCAFEF00D));
        vecs.push_back(mk(0, 1, 0, 1, 2'b11, 0, 32'h100,       32'hAAAAAAAA,  0,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h00,        32'h0,         0,  32'hAAAAAAAA, 0, 32'hAAAAAAAA));
        vecs.push_back(mk(1, 1, 0, 1, 2'b11, 0, 32'h00,        32'h12345678,  0,  32'h0,        0, 32'hAAAAAAAA));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h00,        32'h0,         0,  32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 2'b11, 0, 32'h10,        32'h0,         1,  32'h0,        0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Several stalled cycles with a pending store must leave memory untouched,
        // and a reset while stalled must still clear the word written afterwards.
        applyStimulus(mk(0, 1, 0, 1, 2'b11, 0, 32'h08, 32'h0BADF00D, 2, 32'h0, 0, 32'h0));
        checkOutput(100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk(0, 0, 1, 1, 2'b11, 0, 32'h08, 32'h55555555, 2,
                             32'h0BADF00D, 0, 32'h0BADF00D));
            checkOutput(101 + k);
        end
        applyStimulus(mk(1, 0, 0, 1, 2'b11, 0, 32'h08, 32'h55555555, 2, 32'h0, 0, 32'h0BADF00D));
        checkOutput(104);
        applyStimulus(mk(0, 1, 1, 0, 2'b00, 0, 32'h08, 32'h0, 2, 32'h0, 0, 32'h0));
        checkOutput(105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, required finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
